dense2_ctrl: RTL and testbench
==============================

Name: dense2_ctrl

Overview:
- Sequencer for the second dense layer's 10-lane multiply-accumulate array and its shared weight ROM.
- Buffers one frame of N_IN sigmoid activations from the first dense layer.
- Replays the frame into the array with frame start/end framing, then waits for the array's combined valid and captures the 160-bit sum vector.
- Computes the arg-max class and presents the result on a valid/ready output stream.

Parameters:
- N_IN, 128, activations per frame; 2..256, bounded by the 8-bit weight ROM address.
- DW, 16, activation and sum lane width (signed).
- N_OUT, 10, number of output lanes in the sum vector.
- TIMEOUT, 64, max cycles in WAIT for the array's valid before an error is flagged.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  activation word valid.
- in_ready  out  1  high only in FILL.
- in_data  in  DW  signed activation.
- d2_ena  out  1  array/ROM enable.
- d2_frame_start  out  1  first-element pulse.
- d2_frame_end  out  1  last-element pulse.
- d2_data  out  DW  activation to array.
- d2_valid  in  1  AND of all lane valids.
- d2_sum  in  N_OUT*DW  lane i at bits [i*DW+DW-1 : i*DW].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_sum  out  N_OUT*DW  captured sums.
- out_class  out  4  arg-max lane index.
- err_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset:
  - State goes to FILL; all counters are 0.
  - d2_ena, d2_frame_start, d2_frame_end, d2_data, out_valid, out_sum, out_class and err_timeout are all 0.
  - in_ready is 1 in the cycle after rst deasserts.
  - Reset in any state aborts the frame; buffer contents are don't-care.
- All outputs except in_ready are registered. in_ready is decoded from state.
- FILL:
  - On in_valid & in_ready, write buf[wr_cnt] and increment wr_cnt.
  - On the accept with wr_cnt == N_IN-1, go to RUN and clear wr_cnt.
  - in_valid gaps stall the fill without penalty.
- RUN, for k = 0..N_IN-1 (one element per cycle, no stalls):
  - d2_ena = 1 and d2_data = buf[k].
  - d2_frame_start = (k == 0); d2_frame_end = (k == N_IN-1).
  - After k = N_IN-1, go to WAIT.
- WAIT:
  - d2_ena stays 1 so the ROM and array pipeline keep running; d2_data = 0; both frame pulses are 0.
  - On d2_valid = 1, latch d2_sum into out_sum and go to ARGMAX.
  - If the wait counter reaches TIMEOUT with no valid: set err_timeout, drop d2_ena and return to FILL.
  - err_timeout is cleared only by rst.
- ARGMAX:
  - d2_ena = 0. Iterative over N_OUT cycles, one lane per cycle.
  - Lane 0 seeds the maximum.
  - A later lane replaces the current maximum only if it is strictly greater (signed compare). Ties therefore resolve to the lowest index.
  - Then go to HOLD.
- HOLD:
  - out_valid = 1; out_sum and out_class are stable.
  - On out_valid & out_ready, drop out_valid the next cycle and go to FILL.
  - out_sum and out_class keep their last values until the next capture.
- Latency from the last input accept:
  - First RUN element appears 1 cycle later.
  - Array valid is seen after N_IN RUN cycles plus the array latency.
  - out_valid rises N_OUT+1 cycles after the d2_valid capture.
- No overlap between frames: in_ready = 0 from RUN through the HOLD handshake.
- A d2_valid seen outside WAIT is ignored.

Decomposition:
- Shared package dense_pkg:
  - DW and N_OUT.
  - ROM address width (8).
  - State enum: FILL, RUN, WAIT, ARGMAX, HOLD.
  - Lane-slice helper for the N_OUT*DW sum vector.
- One sub-module: dense_argmax_seq. Sequential signed arg-max over the sum vector with start/done handshake and lowest-index tie rule. It is reusable for the final classifier output.
- Activation buffer is a local register array (N_IN x DW) inside dense2_ctrl.

Test Plan:
1. Basic frame:
   - Stimulus: N_IN = 4, in_data = 1, 2, 3, 4 back-to-back; stub asserts d2_valid 3 cycles after frame_end, with lane 7 = 0x0100 and all other lanes = 0x0010.
   - Required: d2_data sequence 1, 2, 3, 4; frame_start only with 1; frame_end only with 4; out_class = 7; out_valid rises 11 cycles after the capture.
2. Input gaps:
   - Stimulus: in_valid toggled every other cycle.
   - Required: RUN sequence identical to scenario 1; RUN does not begin until the 4th accept.
3. Output backpressure:
   - Stimulus: hold out_ready = 0 for 20 cycles.
   - Required: out_valid, out_sum and out_class stable; in_ready = 0 throughout; in_ready = 1 the cycle after the handshake.
4. Tie and negatives:
   - Stimulus: all lanes = -5 (0xFFFB) except lanes 2 and 6 = 0x0003.
   - Required: out_class = 2.
5. Timeout:
   - Stimulus: stub never asserts d2_valid.
   - Required: err_timeout = 1 after 64 WAIT cycles; d2_ena = 0; state FILL with in_ready = 1; the next frame completes normally with err_timeout still 1.
6. Reset mid-RUN:
   - Stimulus: rst asserted at k = 2.
   - Required: next cycle all outputs are 0 and in_ready = 1; a fresh 4-word frame produces the correct result.

Source files
------------

// File: rtl/dense_pkg.sv
// Shared types and helpers for the dense-layer sequencers: lane geometry,
// controller state encoding and a signed lane extractor for packed sum vectors.
package dense_pkg;

  localparam int DW     = 16;
  localparam int N_OUT  = 10;
  localparam int ROM_AW = 8;
  localparam int CLS_W  = 4;

  typedef enum logic [2:0] {
    FILL,
    RUN,
    WAIT,
    ARGMAX,
    HOLD
  } state_t;

  function automatic logic signed [DW-1:0] lane_of(input logic [N_OUT*DW-1:0] vec,
                                                   input int unsigned idx);
    return $signed(vec[idx*DW +: DW]);
  endfunction

endpackage

// File: rtl/dense2_ctrl_if.sv
// Activation input stream, MAC-array/ROM bus and result stream of the second
// dense layer; master is the sequencer, slave is its surroundings.
interface dense2_ctrl_if;
  import dense_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         in_data;
  logic                  d2_ena;
  logic                  d2_frame_start;
  logic                  d2_frame_end;
  logic [DW-1:0]         d2_data;
  logic                  d2_valid;
  logic [N_OUT*DW-1:0]   d2_sum;
  logic                  out_valid;
  logic                  out_ready;
  logic [N_OUT*DW-1:0]   out_sum;
  logic [CLS_W-1:0]      out_class;
  logic                  err_timeout;

  modport master (
    input  in_valid, in_data, d2_valid, d2_sum, out_ready,
    output in_ready, d2_ena, d2_frame_start, d2_frame_end, d2_data,
           out_valid, out_sum, out_class, err_timeout
  );

  modport slave (
    output in_valid, in_data, d2_valid, d2_sum, out_ready,
    input  in_ready, d2_ena, d2_frame_start, d2_frame_end, d2_data,
           out_valid, out_sum, out_class, err_timeout
  );

endinterface

// File: rtl/dense_argmax_seq.sv
// Sequential signed arg-max over a packed lane vector, one lane per cycle.
// Ties keep the lowest index because only a strictly greater lane takes over.
module dense_argmax_seq
  import dense_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_OUT*DW-1:0] vec,
  output logic                done,
  output logic [CLS_W-1:0]    cls
);

  localparam logic [CLS_W-1:0] LAST_LANE = CLS_W'(N_OUT - 1);

  logic                 busy;
  logic [CLS_W-1:0]     lane;
  logic [CLS_W-1:0]     best_idx;
  logic signed [DW-1:0] best_val;
  logic signed [DW-1:0] cur;
  logic                 better;

  assign cur    = lane_of(vec, int'(lane));
  assign better = cur > best_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      lane     <= '0;
      best_idx <= '0;
      best_val <= '0;
      cls      <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        // lane 0 seeds the running maximum
        busy     <= 1'b1;
        lane     <= CLS_W'(1);
        best_val <= lane_of(vec, 0);
        best_idx <= '0;
      end else if (busy) begin
        if (better) begin
          best_val <= cur;
          best_idx <= lane;
        end
        if (lane == LAST_LANE) begin
          busy <= 1'b0;
          done <= 1'b1;
          cls  <= better ? lane : best_idx;
        end else begin
          lane <= lane + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dense2_ctrl.sv
// Second dense layer sequencer: buffers a frame of activations, replays it into
// the MAC array, captures the lane sums and publishes the arg-max class.
module dense2_ctrl
  import dense_pkg::*;
#(
  parameter int N_IN    = 128,
  parameter int TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst,
  dense2_ctrl_if.master bus
);

  localparam int WR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int RD_W = $clog2(N_IN + 1);
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [WR_W-1:0] LAST_WR = WR_W'(N_IN - 1);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(N_IN - 1);
  localparam logic [RD_W-1:0] RD_DONE = RD_W'(N_IN);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  if (N_IN < 2 || N_IN > (1 << ROM_AW)) begin : g_bad_n_in
    $error("dense2_ctrl: N_IN out of range for the weight ROM address");
  end

  state_t              state;
  logic [WR_W-1:0]     wr_cnt;
  logic [RD_W-1:0]     rd_cnt;
  logic [TO_W-1:0]     wait_cnt;
  logic [DW-1:0]       act_buf [N_IN];

  logic                d2_ena;
  logic                d2_frame_start;
  logic                d2_frame_end;
  logic [DW-1:0]       d2_data;
  logic                out_valid;
  logic [N_OUT*DW-1:0] out_sum;
  logic [CLS_W-1:0]    out_class;
  logic                err_timeout;
  logic                am_start;
  logic                am_done;
  logic [CLS_W-1:0]    am_class;

  assign bus.in_ready       = (state == FILL);
  assign bus.d2_ena         = d2_ena;
  assign bus.d2_frame_start = d2_frame_start;
  assign bus.d2_frame_end   = d2_frame_end;
  assign bus.d2_data        = d2_data;
  assign bus.out_valid      = out_valid;
  assign bus.out_sum        = out_sum;
  assign bus.out_class      = out_class;
  assign bus.err_timeout    = err_timeout;

  // Frame storage needs no reset; a reset simply restarts the fill.
  always_ff @(posedge clk) begin
    if (state == FILL && bus.in_valid) begin
      act_buf[wr_cnt] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FILL;
      wr_cnt         <= '0;
      rd_cnt         <= '0;
      wait_cnt       <= '0;
      d2_ena         <= 1'b0;
      d2_frame_start <= 1'b0;
      d2_frame_end   <= 1'b0;
      d2_data        <= '0;
      out_valid      <= 1'b0;
      out_sum        <= '0;
      out_class      <= '0;
      err_timeout    <= 1'b0;
      am_start       <= 1'b0;
    end else begin
      am_start <= 1'b0;
      case (state)
        FILL: begin
          if (bus.in_valid) begin
            if (wr_cnt == LAST_WR) begin
              // element 0 goes out right away, so RUN shows element k while rd_cnt = k+1
              wr_cnt         <= '0;
              rd_cnt         <= RD_W'(1);
              d2_ena         <= 1'b1;
              d2_frame_start <= 1'b1;
              d2_frame_end   <= 1'b0;
              d2_data        <= act_buf[0];
              state          <= RUN;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          d2_frame_start <= 1'b0;
          if (rd_cnt == RD_DONE) begin
            d2_frame_end <= 1'b0;
            d2_data      <= '0;
            wait_cnt     <= '0;
            state        <= WAIT;
          end else begin
            d2_data      <= act_buf[rd_cnt[WR_W-1:0]];
            d2_frame_end <= (rd_cnt == RD_LAST);
            rd_cnt       <= rd_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (bus.d2_valid) begin
            out_sum  <= bus.d2_sum;
            d2_ena   <= 1'b0;
            am_start <= 1'b1;
            state    <= ARGMAX;
          end else if (wait_cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            d2_ena      <= 1'b0;
            state       <= FILL;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ARGMAX: begin
          if (am_done) begin
            out_class <= am_class;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  dense_argmax_seq u_argmax (
    .clk   (clk),
    .rst   (rst),
    .start (am_start),
    .vec   (out_sum),
    .done  (am_done),
    .cls   (am_class)
  );

endmodule

// File: tb/tb_dense2_ctrl.sv
// Self-checking bench for dense2_ctrl with a 4-word frame and a stub MAC array
// that answers three cycles after frame_end.
module tb_dense2_ctrl;
  import dense_pkg::*;

  localparam int NI = 4;

  typedef struct packed {
    logic [15:0] data;
    logic        first;
    logic        last;
  } exp_elem_t;

  typedef struct packed {
    logic [159:0] sum;
    logic [3:0]   cls;
  } exp_res_t;

  typedef struct {
    logic [63:0]  words;
    logic [159:0] sum;
    logic [3:0]   cls;
    bit           gaps;
    int           hold;
  } vec_t;

  logic clk;
  logic rst;
  dense2_ctrl_if bus ();

  dense2_ctrl #(.N_IN(NI), .TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int cap_edge = -100;
  bit stub_respond = 1'b1;
  logic [159:0] stub_sum = '0;
  exp_elem_t exp_data_q[$];
  exp_res_t  exp_res_q[$];
  vec_t vecs[7];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycle = cycle + 1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: wait bound expired, got timeout expected event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [159:0] mk_sum(input logic [15:0] base, input int l1, input logic [15:0] v1,
                                          input int l2, input logic [15:0] v2);
    logic [159:0] s;
    for (int i = 0; i < 10; i++) s[i*16 +: 16] = (i == l1) ? v1 : ((i == l2) ? v2 : base);
    return s;
  endfunction

  // Stub MAC array: answers with stub_sum three cycles after frame_end.
  initial begin
    bus.d2_valid = 1'b0;
    bus.d2_sum   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.d2_frame_end && stub_respond) begin
        repeat (3) tick();
        bus.d2_sum   = stub_sum;
        bus.d2_valid = 1'b1;
        cap_edge     = cycle + 1;
        tick();
        bus.d2_valid = 1'b0;
      end
    end
  end

  // Array-side monitor: every framed element is popped from the scoreboard.
  initial begin
    bit in_frame;
    exp_elem_t e;
    in_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.d2_ena && (bus.d2_frame_start || in_frame)) begin
        if (exp_data_q.size() == 0) begin
          checkOutput("d2_unexpected_element", 160'(bus.d2_data), 160'hDEAD);
        end else begin
          e = exp_data_q.pop_front();
          checkOutput("d2_data", 160'(bus.d2_data), 160'(e.data));
          checkOutput("d2_frame_start", 160'(bus.d2_frame_start), 160'(e.first));
          checkOutput("d2_frame_end", 160'(bus.d2_frame_end), 160'(e.last));
        end
        in_frame = !bus.d2_frame_end;
      end else if (!bus.d2_ena) begin
        in_frame = 1'b0;
      end
    end
  end

  // Result-side monitor: handshake compares, plus capture-to-valid latency.
  initial begin
    bit prev_ov;
    exp_res_t r;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && !prev_ov)
        checkOutput("out_valid_latency", 160'(cycle - cap_edge), 160'(11));
      prev_ov = (bus.out_valid === 1'b1);
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        if (exp_res_q.size() == 0) begin
          checkOutput("out_unexpected_result", 160'(bus.out_class), 160'hBEEF);
        end else begin
          r = exp_res_q.pop_front();
          checkOutput("out_class", 160'(bus.out_class), 160'(r.cls));
          checkOutput("out_sum", bus.out_sum, r.sum);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [63:0] words, input logic [159:0] sum, input logic [3:0] cls,
                               input bit gaps, input bit want_result);
    exp_elem_t e;
    int cnt;
    stub_sum = sum;
    if (want_result) exp_res_q.push_back({sum, cls});
    for (int i = 0; i < NI; i++) begin
      if (gaps && i > 0) begin
        bus.in_valid = 1'b0;
        tick();
      end
      cnt = 0;
      while (bus.in_ready !== 1'b1 && cnt < 200) begin
        tick();
        cnt++;
      end
      if (cnt >= 200) reportTimeout("in_ready_wait");
      e.data  = words[i*16 +: 16];
      e.first = (i == 0);
      e.last  = (i == NI - 1);
      exp_data_q.push_back(e);
      bus.in_valid = 1'b1;
      bus.in_data  = e.data;
      tick();
      if (i < NI - 1) checkOutput("no_early_run", 160'(bus.d2_ena), 160'(0));
    end
    bus.in_valid = 1'b0;
    checkOutput("run_started", 160'(bus.d2_ena), 160'(1));
  endtask

  task automatic waitResult(input int hold);
    int cnt;
    logic [159:0] s0;
    logic [3:0] c0;
    bit stable;
    bit rdy_low;
    cnt = 0;
    while (bus.out_valid !== 1'b1 && cnt < 300) begin
      tick();
      cnt++;
    end
    if (cnt >= 300) begin
      reportTimeout("out_valid_wait");
      return;
    end
    checkOutput("hold_in_ready", 160'(bus.in_ready), 160'(0));
    if (hold > 0) begin
      s0 = bus.out_sum;
      c0 = bus.out_class;
      stable = 1'b1;
      rdy_low = 1'b1;
      repeat (hold) begin
        tick();
        if (!(bus.out_valid === 1'b1 && bus.out_sum === s0 && bus.out_class === c0)) stable = 1'b0;
        if (bus.in_ready !== 1'b0) rdy_low = 1'b0;
      end
      checkOutput("bp_output_stable", 160'(stable), 160'(1));
      checkOutput("bp_in_ready_low", 160'(rdy_low), 160'(1));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("post_hs_out_valid", 160'(bus.out_valid), 160'(0));
    checkOutput("post_hs_in_ready", 160'(bus.in_ready), 160'(1));
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{64'h0004_0003_0002_0001, mk_sum(16'h0010, 7, 16'h0100, -1, 16'h0), 4'd7, 1'b0, 0};
    vecs[1] = '{64'h0004_0003_0002_0001, mk_sum(16'h0010, 7, 16'h0100, -1, 16'h0), 4'd7, 1'b1, 0};
    vecs[2] = '{64'h0008_0007_0006_0005, mk_sum(16'h0020, 3, 16'h0030, -1, 16'h0), 4'd3, 1'b0, 20};
    vecs[3] = '{64'h0000_7FFF_8000_FFFF, mk_sum(16'hFFFB, 2, 16'h0003, 6, 16'h0003), 4'd2, 1'b0, 0};
    vecs[4] = '{64'h0011_0022_0033_0044, mk_sum(16'h8000, 9, 16'h7FFF, -1, 16'h0), 4'd9, 1'b1, 3};
    vecs[5] = '{64'h1111_2222_3333_4444, mk_sum(16'h1234, -1, 16'h0, -1, 16'h0), 4'd0, 1'b0, 0};
    vecs[6] = '{64'hFFFE_FFFD_0001_0002, mk_sum(16'hFFFF, 0, 16'h0005, -1, 16'h0), 4'd0, 1'b0, 1};

    repeat (3) tick();
    checkOutput("reset_d2_ena", 160'(bus.d2_ena), 160'(0));
    checkOutput("reset_d2_data", 160'(bus.d2_data), 160'(0));
    checkOutput("reset_out_valid", 160'(bus.out_valid), 160'(0));
    checkOutput("reset_out_sum", bus.out_sum, 160'(0));
    checkOutput("reset_err_timeout", 160'(bus.err_timeout), 160'(0));
    rst = 1'b0;
    tick();
    checkOutput("reset_in_ready", 160'(bus.in_ready), 160'(1));

    $display("[TB] table-driven frames");
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].words, vecs[v].sum, vecs[v].cls, vecs[v].gaps, 1'b1);
      waitResult(vecs[v].hold);
    end

    $display("[TB] timeout sequence");
    stub_respond = 1'b0;
    applyStimulus(64'h00AA_00BB_00CC_00DD, '0, 4'd0, 1'b0, 1'b0);
    cnt = 0;
    while (bus.err_timeout !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
      if (cnt == 20) begin
        checkOutput("wait_d2_ena_high", 160'(bus.d2_ena), 160'(1));
        checkOutput("wait_d2_data_zero", 160'(bus.d2_data), 160'(0));
      end
    end
    checkOutput("timeout_latency", 160'(cnt), 160'(NI + 64));
    checkOutput("timeout_d2_ena", 160'(bus.d2_ena), 160'(0));
    checkOutput("timeout_in_ready", 160'(bus.in_ready), 160'(1));
    stub_respond = 1'b1;
    applyStimulus(64'h000C_000B_000A_0009, mk_sum(16'h0001, 5, 16'h0002, -1, 16'h0), 4'd5, 1'b0, 1'b1);
    waitResult(0);
    checkOutput("err_sticky", 160'(bus.err_timeout), 160'(1));

    $display("[TB] reset during RUN");
    applyStimulus(64'h0400_0300_0200_0100, '0, 4'd0, 1'b0, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_data_q.delete();
    checkOutput("rst_run_d2_ena", 160'(bus.d2_ena), 160'(0));
    checkOutput("rst_run_frame_pulses", 160'({bus.d2_frame_start, bus.d2_frame_end}), 160'(0));
    checkOutput("rst_run_d2_data", 160'(bus.d2_data), 160'(0));
    checkOutput("rst_run_out_sum", bus.out_sum, 160'(0));
    checkOutput("rst_run_out_class", 160'(bus.out_class), 160'(0));
    checkOutput("rst_run_err", 160'(bus.err_timeout), 160'(0));
    checkOutput("rst_run_in_ready", 160'(bus.in_ready), 160'(1));
    applyStimulus(64'h0400_0300_0200_0100, mk_sum(16'h0000, 4, 16'h7FFF, -1, 16'h0), 4'd4, 1'b0, 1'b1);
    waitResult(0);

    repeat (3) tick();
    checkOutput("data_queue_drained", 160'(exp_data_q.size()), 160'(0));
    checkOutput("result_queue_drained", 160'(exp_res_q.size()), 160'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
